// File: rtl/gpc_stream_accum.sv
// Pipelined generalised parallel counter with valid/ready packet accumulator.
// Optional macro GPC_ACC_SAT_EN: saturate the accumulator instead of wrapping it.
module gpc_stream_accum #(
   parameter int H0    = 6,
   parameter int H1    = 0,
   parameter int H2    = 4,
   parameter int H3    = 1,
   parameter int ACC_W = 12,
   parameter int CNT_W = 8,
   localparam int SRC_W = H0 + H1 + H2 + H3,
   localparam int GPC_W = $clog2(H0 + 2*H1 + 4*H2 + 8*H3 + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   input  logic [SRC_W-1:0] src,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_beats,
   output logic             out_ovf
);

`ifdef GPC_ACC_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   localparam int EXT_W = ((GPC_W > ACC_W) ? GPC_W : ACC_W) + 1;

   typedef enum logic {EMPTY, ACCUM} state_t;

   state_t             state, state_d;
   logic               s1_valid, s1_last, s1_adv, s1_fire;
   logic [GPC_W-1:0]   s1_sum;
   logic [ACC_W-1:0]   acc, acc_base, acc_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic               ovf, ovf_next, carry;
   logic [EXT_W-1:0]   total;

   // Column index of each packed source bit decides its weight (1 << column).
   function automatic logic [GPC_W-1:0] gpc_sum(input logic [SRC_W-1:0] bits);
      logic [GPC_W-1:0] s;
      int               col;
      s = '0;
      for (int i = 0; i < SRC_W; i++) begin
         if (i < H0)                col = 0;
         else if (i < H0 + H1)      col = 1;
         else if (i < H0 + H1 + H2) col = 2;
         else                       col = 3;
         if (bits[i]) s = s + GPC_W'(1 << col);
      end
      return s;
   endfunction

   function automatic logic [ACC_W-1:0] acc_limit(input logic [EXT_W-1:0] t);
      if (SAT_EN && (|t[EXT_W-1:ACC_W])) return '1;
      return t[ACC_W-1:0];
   endfunction

   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      if (c == '1) return c;
      return c + CNT_W'(1);
   endfunction

   assign s1_adv   = !(s1_last && out_valid && !out_ready);
   assign in_ready = !s1_valid || s1_adv;
   assign s1_fire  = s1_valid && s1_adv;

   assign acc_base = (state == ACCUM) ? acc : '0;
   assign total    = EXT_W'(acc_base) + EXT_W'(s1_sum);
   assign carry    = |total[EXT_W-1:ACC_W];
   assign acc_next = acc_limit(total);
   assign cnt_next = cnt_inc((state == ACCUM) ? cnt : '0);
   assign ovf_next = ((state == ACCUM) && ovf) || carry;

   // S1: column compression
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         s1_last  <= in_valid && in_last;
      end
   end

   always_ff @(posedge clk) begin
      if (in_ready && in_valid) s1_sum <= gpc_sum(src);
   end

   // S2: packet accumulation and result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      if (s1_fire) state_d = s1_last ? EMPTY : ACCUM;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_beats <= '0;
         out_ovf   <= 1'b0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (s1_fire) begin
            if (s1_last) begin
               out_valid <= 1'b1;
               out_sum   <= acc_next;
               out_beats <= cnt_next;
               out_ovf   <= ovf_next;
               acc       <= '0;
               cnt       <= '0;
               ovf       <= 1'b0;
            end else begin
               acc <= acc_next;
               cnt <= cnt_next;
               ovf <= ovf_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_gpc_stream_accum.sv
// Scoreboard bench for gpc_stream_accum: default, ACC_W=5 and H0=3/H1=2 instances.
module tb_gpc_stream_accum;

   typedef struct {
      logic [11:0] sum;
      logic [7:0]  beats;
      logic        ovf;
   } res_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   res_t q_m[$];
   res_t q_s[$];
   res_t q_h[$];

   // default instance
   logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic [10:0] src = '0;
   logic        in_ready, out_valid, out_ovf;
   logic [11:0] out_sum;
   logic [7:0]  out_beats;

   // ACC_W=5 instance
   logic        in_valid_s = 1'b0, in_last_s = 1'b0, out_ready_s = 1'b1;
   logic [10:0] src_s = '0;
   logic        in_ready_s, out_valid_s, out_ovf_s;
   logic [4:0]  out_sum_s;
   logic [7:0]  out_beats_s;

   // H0=3, H1=2 instance
   logic        in_valid_h = 1'b0, in_last_h = 1'b0, out_ready_h = 1'b1;
   logic [4:0]  src_h = '0;
   logic        in_ready_h, out_valid_h, out_ovf_h;
   logic [11:0] out_sum_h;
   logic [7:0]  out_beats_h;

   gpc_stream_accum dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_last(in_last), .src(src), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_beats(out_beats), .out_ovf(out_ovf));

   gpc_stream_accum #(.ACC_W(5)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
      .in_last(in_last_s), .src(src_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
      .out_sum(out_sum_s), .out_beats(out_beats_s), .out_ovf(out_ovf_s));

   gpc_stream_accum #(.H0(3), .H1(2), .H2(0), .H3(0)) dut_h (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_h), .in_ready(in_ready_h),
      .in_last(in_last_h), .src(src_h), .out_valid(out_valid_h), .out_ready(out_ready_h),
      .out_sum(out_sum_h), .out_beats(out_beats_h), .out_ovf(out_ovf_h));

   // {col3, col2, col0}: 12 = 4+8, 17 = 1+8+8, 18 = 2+16
   localparam logic [10:0] S12 = {1'b0, 4'ha, 6'h2d};
   localparam logic [10:0] S17 = {1'b1, 4'h5, 6'h20};
   localparam logic [10:0] S18 = {1'b0, 4'hf, 6'h03};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic send(input logic [10:0] s, input logic l);
      in_valid = 1'b1;
      src      = s;
      in_last  = l;
      #1 check("send_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic expect_m(input logic [11:0] sum, input logic [7:0] beats, input logic ovf);
      res_t r;
      r.sum = sum; r.beats = beats; r.ovf = ovf;
      q_m.push_back(r);
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s: result presented with empty scoreboard", name);
   endtask

   // Monitor runs after the bench has driven this half-cycle's inputs.
   always begin : mon
      res_t r;
      @(negedge clk);
      #2;
      if (rst_n === 1'b1) begin
         if (out_valid && out_ready) begin
            if (q_m.size() == 0) unexpected("main_extra");
            else begin
               r = q_m.pop_front();
               check("main_sum", out_sum, r.sum);
               check("main_beats", out_beats, r.beats);
               check("main_ovf", out_ovf, r.ovf);
            end
         end
         if (out_valid_s && out_ready_s) begin
            if (q_s.size() == 0) unexpected("acc5_extra");
            else begin
               r = q_s.pop_front();
               check("acc5_sum", out_sum_s, r.sum);
               check("acc5_beats", out_beats_s, r.beats);
               check("acc5_ovf", out_ovf_s, r.ovf);
            end
         end
         if (out_valid_h && out_ready_h) begin
            if (q_h.size() == 0) unexpected("h32_extra");
            else begin
               r = q_h.pop_front();
               check("h32_sum", out_sum_h, r.sum);
               check("h32_beats", out_beats_h, r.beats);
               check("h32_ovf", out_ovf_h, r.ovf);
            end
         end
      end
   end

   initial begin
      res_t r;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_beats", out_beats, 0);
      check("rst_out_ovf", out_ovf, 0);
      check("rst_acc", dut.acc, 0);
      step();
      rst_n = 1'b1;
      step();

      // single beat: two-edge latency
      expect_m(12, 1, 0);
      send(S12, 1'b1);
      #1 check("lat_edge1_valid", out_valid, 0);
      step();
      #1 check("lat_edge2_valid", out_valid, 1);
      step();
      step();

      // three beats back-to-back
      expect_m(47, 3, 0);
      send(S12, 1'b0);
      send(S17, 1'b0);
      send(S18, 1'b1);
      step();
      step();
      step();

      // backpressure on the result register
      out_ready = 1'b0;
      expect_m(12, 1, 0);
      send(S12, 1'b1);
      step();
      #1 check("bp_first_valid", out_valid, 1);
      check("bp_first_sum", out_sum, 12);
      expect_m(17, 1, 0);
      send(S17, 1'b1);
      for (int i = 0; i < 2; i++) begin
         #1 check("bp_stall_ready", in_ready, 0);
         check("bp_hold_sum", out_sum, 12);
         step();
      end
      out_ready = 1'b1;
      #1 check("bp_release_ready", in_ready, 1);
      step();
      #1 check("bp_stay_valid", out_valid, 1);
      check("bp_new_sum", out_sum, 17);
      step();
      step();

      // asynchronous reset mid-packet
      send(S12, 1'b0);
      send(S17, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_sum", out_sum, 0);
      check("mid_rst_out_beats", out_beats, 0);
      check("mid_rst_acc", dut.acc, 0);
      check("mid_rst_cnt", dut.cnt, 0);
      check("mid_rst_s1_valid", dut.s1_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      step();
      rst_n = 1'b1;
      step();
      expect_m(12, 1, 0);
      send(S12, 1'b1);
      step();
      step();

      // beat counter saturation
      expect_m(12, 255, 0);
      for (int i = 0; i < 299; i++) send(11'h000, 1'b0);
      send(S12, 1'b1);
      step();
      step();

      // ACC_W=5: 30 + 30 overflows
`ifdef GPC_ACC_SAT_EN
      r.sum = 31;
`else
      r.sum = 28;
`endif
      r.beats = 2; r.ovf = 1'b1;
      q_s.push_back(r);
      in_valid_s = 1'b1; src_s = 11'h7ff; in_last_s = 1'b0;
      step();
      in_last_s = 1'b1;
      step();
      in_valid_s = 1'b0; in_last_s = 1'b0;
      step();
      step();

      // H0=3, H1=2: col0=3'b101 -> 2, col1=2'b11 -> 4
      r.sum = 6; r.beats = 1; r.ovf = 1'b0;
      q_h.push_back(r);
      in_valid_h = 1'b1; src_h = 5'b11_101; in_last_h = 1'b1;
      step();
      in_valid_h = 1'b0; in_last_h = 1'b0;
      step();
      step();
      step();

      check("main_queue_drained", q_m.size(), 0);
      check("acc5_queue_drained", q_s.size(), 0);
      check("h32_queue_drained", q_h.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
